if_fetch_queue: RTL and testbench
=================================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning maximum requests in flight plus buffered (power of 2, 2..16).
REQ-002 SHALL have parameter FETCH_W, default 2, meaning instructions per response beat (1, 2 or 4).
REQ-003 SHALL have parameter PC_W, default 32, meaning PC width.
REQ-004 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port req_issue_i  in  1  icache accepted a fetch request this cycle.
REQ-007 SHALL have port req_pc_i  in  PC_W  PC of the accepted request.
REQ-008 SHALL have port inst_sram_data_ok_i  in  1  one in-order response beat returned.
REQ-009 SHALL have port inst_sram_rdata_i  in  32*FETCH_W  response beat, lane k at bits [32k+31:32k].
REQ-010 SHALL have port excep_flush_i  in  1  exception flush.
REQ-011 SHALL have port banch_flush_i  in  1  branch flush.
REQ-012 SHALL have port next_allowin_i  in  1  ID stage accepts a beat.
REQ-013 SHALL have port now_allowin_o  out  1  preif may issue a new request.
REQ-014 SHALL have port now_to_next_valid_o  out  1  head beat valid to ID.
REQ-015 SHALL have port lane_valid_o  out  FETCH_W  per-lane instruction valid.
REQ-016 SHALL have port pc_o  out  PC_W  head beat PC.
REQ-017 SHALL have port inst_o  out  32*FETCH_W  head beat instructions.

Function
REQ-018 SHALL hold a circular queue of DEPTH entries {pc, filled, data}; req_issue_i allocates at tail with filled=0.
REQ-019 SHALL write each non-cancelled data_ok beat into the oldest unfilled entry and set filled.
REQ-020 SHALL assert now_to_next_valid_o when the head entry is filled; a beat written in cycle t is visible no earlier than t+1 (no bypass).
REQ-021 SHALL pop the head when now_to_next_valid_o && next_allowin_i; pop and allocate in the same cycle SHALL both take effect.
REQ-022 SHALL drive now_allowin_o = (occupancy + cancel_cnt) < DEPTH, so neither the queue nor cancel_cnt can overflow.
REQ-023 SHALL set lane_valid_o[k] = (k >= pc_o word index within the FETCH_W-word block); lanes below the entry offset are 0.
REQ-024 SHALL, when excep_flush_i or banch_flush_i is asserted, clear all entries and force now_to_next_valid_o=0 in that cycle.
REQ-025 SHALL, on flush, add to cancel_cnt the unfilled entries, plus 1 if req_issue_i is high in the flush cycle, minus 1 if an uncancelled data_ok arrives in that cycle.
REQ-026 SHALL discard a data_ok beat while cancel_cnt>0 and decrement cancel_cnt; cancel_cnt width is clog2(DEPTH+1).
REQ-027 SHALL treat excep_flush_i and banch_flush_i asserted together as a single flush.
REQ-028 SHALL keep cancel_cnt counting down across any number of back-to-back flushes.

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear head, tail, filled bits and cancel_cnt.
REQ-030 SHALL drive now_to_next_valid_o=0, lane_valid_o=0, now_allowin_o=1, pc_o=0 and inst_o=0 during reset and in the first cycle after release.

Configuration
REQ-031 SHALL, with IF_FETCH_QUEUE_PERF_EN defined, provide 32-bit saturating outputs perf_cancel_cnt_o (discarded beats) and perf_stall_cnt_o (cycles with valid && !next_allowin_i), both reset to 0.
REQ-032 SHALL, without IF_FETCH_QUEUE_PERF_EN, have no such ports and no counter logic.

Structure
REQ-033 SHALL place the queue entry struct, the lane-offset function and the DEPTH/FETCH_W legality constants in the shared package if_pkg.
REQ-034 SHALL instantiate one sub-module, ifq_cancel_ctr, which holds cancel_cnt and produces the data_ok accept/discard decision.

Verification
REQ-035 SHALL cover: 4 issues, 4 data_ok, next_allowin_i=1 -> 4 beats out in order, the first one cycle after its data_ok.
REQ-036 SHALL cover: 3 issues, 1 data_ok, then flush -> cancel_cnt=2, the next 2 data_ok discarded, the 3rd accepted.
REQ-037 SHALL cover: flush in the same cycle as data_ok and req_issue_i with 2 unfilled -> cancel_cnt=2.
REQ-038 SHALL cover: next_allowin_i=0, DEPTH issues -> now_allowin_o=0 until one pop.
REQ-039 SHALL cover: FETCH_W=2, pc=0x1c004 -> lane_valid_o=2'b10; pc=0x1c000 -> lane_valid_o=2'b11.
REQ-040 SHALL cover: rst_n low mid-transfer with cancel_cnt=3 -> all outputs at reset values and cancel_cnt=0 immediately.

Source files
------------

// File: rtl/if_fetch_queue_pkg.sv
// Shared types and helpers for the instruction fetch queue (package if_pkg).
package if_pkg;

  // Legal parameter ranges for the fetch queue.
  localparam int IFQ_DEPTH_MIN   = 2;
  localparam int IFQ_DEPTH_MAX   = 16;
  localparam int IFQ_FETCH_W_MAX = 4;
  localparam int IFQ_PC_W_MIN    = 4;
  localparam int IFQ_PC_W_MAX    = 64;
  localparam int IFQ_DATA_W_MAX  = 32 * IFQ_FETCH_W_MAX;

  // One queue slot; sized for the widest legal build, narrower builds use the low bits.
  typedef struct packed {
    logic [IFQ_PC_W_MAX-1:0]   pc;
    logic                      filled;
    logic [IFQ_DATA_W_MAX-1:0] data;
  } ifq_entry_t;

  function automatic bit legal_depth(input int depth);
    return (depth >= IFQ_DEPTH_MIN) && (depth <= IFQ_DEPTH_MAX) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit legal_fetch_w(input int fetch_w);
    return (fetch_w == 1) || (fetch_w == 2) || (fetch_w == 4);
  endfunction

  // Word index of a PC inside its FETCH_W-word fetch block, from PC bits [3:2].
  function automatic logic [1:0] lane_offset(input logic [1:0] pc_word, input int fetch_w);
    logic [1:0] off;
    off = 2'b00;
    if (fetch_w == IFQ_FETCH_W_MAX) off = pc_word;
    else if (fetch_w == 2)          off = {1'b0, pc_word[0]};
    return off;
  endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue handshake bundle: master is the fetch/ID side, slave is the queue.
interface if_fetch_queue_if #(
  parameter int FETCH_W = 2,
  parameter int PC_W    = 32
);
  logic                    req_issue_i;
  logic [PC_W-1:0]         req_pc_i;
  logic                    inst_sram_data_ok_i;
  logic [32*FETCH_W-1:0]   inst_sram_rdata_i;
  logic                    excep_flush_i;
  logic                    banch_flush_i;
  logic                    next_allowin_i;
  logic                    now_allowin_o;
  logic                    now_to_next_valid_o;
  logic [FETCH_W-1:0]      lane_valid_o;
  logic [PC_W-1:0]         pc_o;
  logic [32*FETCH_W-1:0]   inst_o;

  modport master (
    output req_issue_i, req_pc_i, inst_sram_data_ok_i, inst_sram_rdata_i,
           excep_flush_i, banch_flush_i, next_allowin_i,
    input  now_allowin_o, now_to_next_valid_o, lane_valid_o, pc_o, inst_o
  );

  modport slave (
    input  req_issue_i, req_pc_i, inst_sram_data_ok_i, inst_sram_rdata_i,
           excep_flush_i, banch_flush_i, next_allowin_i,
    output now_allowin_o, now_to_next_valid_o, lane_valid_o, pc_o, inst_o
  );
endinterface

// File: rtl/if_fetch_queue_cancel_ctr.sv
// Counts responses still owed for flushed requests and decides accept/discard per beat.
module ifq_cancel_ctr
  import if_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_ok_i,
  input  logic             flush_i,
  input  logic [CNT_W-1:0] add_i,
  output logic             accept_o,
  output logic             discard_o,
  output logic [CNT_W-1:0] cancel_cnt_o
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  assign discard_o    = data_ok_i && (cnt_q != '0);
  assign accept_o     = data_ok_i && (cnt_q == '0);
  assign cancel_cnt_o = cnt_q;

  // A beat always consumes one owed response, whether it is discarded or fills a flushed slot.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n)          cnt_q <= '0;
    else if (flush_i)    cnt_q <= cnt_q + add_i - CNT_W'(data_ok_i);
    else if (discard_o)  cnt_q <= cnt_q - CNT_ONE;
  end
endmodule

// File: rtl/if_fetch_queue.sv
// In-order instruction fetch queue between icache responses and the ID stage.
// Optional build macro IF_FETCH_QUEUE_PERF_EN adds saturating perf counters.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int FETCH_W = 2,
  parameter int PC_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  if_fetch_queue_if.slave     bus
`ifdef IF_FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]         perf_cancel_cnt_o,
  output logic [31:0]         perf_stall_cnt_o
`endif
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int DATA_W = 32 * FETCH_W;
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   head_q, tail_q, fill_q;
  logic [PTR_W-1:0] head_idx, tail_idx, fill_idx;
  ifq_entry_t       q_mem [DEPTH];
  ifq_entry_t       head_entry;
  logic             flush, out_valid, pop, alloc, accept, discard;
  logic [PTR_W:0]   occupancy, unfilled;
  logic [CNT_W-1:0] cancel_cnt, cancel_add;
  logic [1:0]       lane_off;
  logic             unused_head;

  assign flush      = bus.excep_flush_i | bus.banch_flush_i;
  assign head_idx   = head_q[PTR_W-1:0];
  assign tail_idx   = tail_q[PTR_W-1:0];
  assign fill_idx   = fill_q[PTR_W-1:0];
  assign occupancy  = tail_q - head_q;
  assign unfilled   = tail_q - fill_q;
  assign head_entry = q_mem[head_idx];
  assign out_valid  = head_entry.filled && !flush;
  assign pop        = out_valid && bus.next_allowin_i;
  assign alloc      = bus.req_issue_i;
  assign cancel_add = CNT_W'(unfilled) + CNT_W'(bus.req_issue_i);
  assign unused_head = ^head_entry;

  ifq_cancel_ctr #(.CNT_W(CNT_W)) u_cancel_ctr (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_ok_i    (bus.inst_sram_data_ok_i),
    .flush_i      (flush),
    .add_i        (cancel_add),
    .accept_o     (accept),
    .discard_o    (discard),
    .cancel_cnt_o (cancel_cnt)
  );

  // Owed responses count against capacity so a late beat always has somewhere to go.
  assign bus.now_allowin_o = ({1'b0, occupancy} + (PTR_W + 2)'(cancel_cnt)) < (PTR_W + 2)'(DEPTH);

  // Head, tail and fill pointers; fill tracks the oldest entry still waiting for data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
    end else if (flush) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
    end else begin
      if (pop)    head_q <= head_q + PTR_ONE;
      if (alloc)  tail_q <= tail_q + PTR_ONE;
      if (accept) fill_q <= fill_q + PTR_ONE;
    end
  end

  // Entry storage: allocate at tail, fill in order, release at head.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: only the filled flags are reset; pc/data payload is never observed unless filled is set.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q_mem[i].filled <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) q_mem[i].filled <= 1'b0;
    end else begin
      if (pop) q_mem[head_idx].filled <= 1'b0;
      if (alloc) begin
        q_mem[tail_idx].pc     <= IFQ_PC_W_MAX'(bus.req_pc_i);
        q_mem[tail_idx].filled <= 1'b0;
      end
      if (accept) begin
        q_mem[fill_idx].data   <= IFQ_DATA_W_MAX'(bus.inst_sram_rdata_i);
        q_mem[fill_idx].filled <= 1'b1;
      end
    end
  end

  assign bus.now_to_next_valid_o = out_valid;
  assign bus.pc_o   = out_valid ? head_entry.pc[PC_W-1:0]     : '0;
  assign bus.inst_o = out_valid ? head_entry.data[DATA_W-1:0] : '0;

  // Lanes below the PC's word offset inside the fetch block carry no instruction.
  always_comb begin
    // NOTE: defaults first so every path assigns every bit and no latch is inferred.
    bus.lane_valid_o = '0;
    lane_off = lane_offset(head_entry.pc[3:2], FETCH_W);
    for (int k = 0; k < FETCH_W; k++) begin
      bus.lane_valid_o[k] = out_valid && (k >= int'(lane_off));
    end
  end

`ifdef IF_FETCH_QUEUE_PERF_EN
  // Saturating counters for discarded beats and ID back-pressure cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cancel_cnt_o <= '0;
      perf_stall_cnt_o  <= '0;
    end else begin
      if (discard && (perf_cancel_cnt_o != '1))
        perf_cancel_cnt_o <= perf_cancel_cnt_o + 32'd1;
      if (out_valid && !bus.next_allowin_i && (perf_stall_cnt_o != '1))
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif
endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed corner sequences, a lane table, random traffic.
module tb_if_fetch_queue;
  localparam int DEPTH   = 4;
  localparam int FETCH_W = 2;
  localparam int PC_W    = 32;
  localparam int DW      = 32 * FETCH_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_fetch_queue_if #(.FETCH_W(FETCH_W), .PC_W(PC_W)) bus ();
`ifdef IF_FETCH_QUEUE_PERF_EN
  logic [31:0] perf_cancel_cnt, perf_stall_cnt;
`endif

  if_fetch_queue #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .PC_W(PC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IF_FETCH_QUEUE_PERF_EN
    ,
    .perf_cancel_cnt_o (perf_cancel_cnt),
    .perf_stall_cnt_o  (perf_stall_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: a queue of outstanding fetches ----------------
  typedef struct {
    logic [PC_W-1:0] pc;
    bit              filled;
    logic [DW-1:0]   data;
  } m_entry_t;

  m_entry_t mq[$];
  int m_cancel, m_discards, m_stalls;

  function automatic bit m_flush();
    return bus.excep_flush_i || bus.banch_flush_i;
  endfunction

  function automatic bit m_valid();
    return (mq.size() > 0) && mq[0].filled && !m_flush();
  endfunction

  function automatic bit m_allowin();
    return (mq.size() + m_cancel) < DEPTH;
  endfunction

  function automatic int m_unfilled();
    int n = 0;
    foreach (mq[i]) if (!mq[i].filled) n++;
    return n;
  endfunction

  function automatic logic [FETCH_W-1:0] m_lanes(input logic [PC_W-1:0] pc);
    int off;
    logic [FETCH_W-1:0] l;
    off = int'((pc % (4 * FETCH_W)) / 4);
    l = '0;
    for (int k = 0; k < FETCH_W; k++) if (k >= off) l[k] = 1'b1;
    return l;
  endfunction

  function automatic logic [DW-1:0] pat(input int n);
    logic [DW-1:0] d;
    for (int k = 0; k < FETCH_W; k++) d[32*k +: 32] = 32'hA000_0000 + 32'(n * 16 + k);
    return d;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cancel = 0;
    m_discards = 0;
    m_stalls = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic m_step();
    bit pop;
    bit dok;
    int idx;
    pop = m_valid() && bus.next_allowin_i;
    dok = bus.inst_sram_data_ok_i;
    if (m_valid() && !bus.next_allowin_i) m_stalls++;
    if (dok && (m_cancel > 0)) m_discards++;
    if (m_flush()) begin
      m_cancel = m_cancel + m_unfilled() + int'(bus.req_issue_i) - int'(dok);
      mq.delete();
    end else begin
      if (dok) begin
        if (m_cancel > 0) m_cancel--;
        else begin
          idx = -1;
          for (int i = 0; i < mq.size(); i++) if (!mq[i].filled && idx < 0) idx = i;
          if (idx >= 0) begin
            mq[idx].filled = 1'b1;
            mq[idx].data   = bus.inst_sram_rdata_i;
          end
        end
      end
      if (pop) void'(mq.pop_front());
      if (bus.req_issue_i) mq.push_back('{pc: bus.req_pc_i, filled: 1'b0, data: '0});
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, " allowin"}, 128'(bus.now_allowin_o), 128'(m_allowin()));
    check({tag, " valid"}, 128'(bus.now_to_next_valid_o), 128'(m_valid()));
    if (m_valid()) begin
      check({tag, " pc"}, 128'(bus.pc_o), 128'(mq[0].pc));
      check({tag, " lanes"}, 128'(bus.lane_valid_o), 128'(m_lanes(mq[0].pc)));
      check({tag, " inst"}, 128'(bus.inst_o), 128'(mq[0].data));
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " allowin"}, 128'(bus.now_allowin_o), 128'(1));
    check({tag, " valid"}, 128'(bus.now_to_next_valid_o), 128'(0));
    check({tag, " lanes"}, 128'(bus.lane_valid_o), 128'(0));
    check({tag, " pc"}, 128'(bus.pc_o), 128'(0));
    check({tag, " inst"}, 128'(bus.inst_o), 128'(0));
  endtask

  task automatic drive(input bit issue, input logic [PC_W-1:0] pc, input bit dok,
                       input logic [DW-1:0] data, input bit ex, input bit br, input bit nallow);
    bus.req_issue_i         = issue;
    bus.req_pc_i            = pc;
    bus.inst_sram_data_ok_i = dok;
    bus.inst_sram_rdata_i   = data;
    bus.excep_flush_i       = ex;
    bus.banch_flush_i       = br;
    bus.next_allowin_i      = nallow;
  endtask

  task automatic at_neg(input string tag);
    @(negedge clk);
    compare_model(tag);
  endtask

  task automatic at_pos();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic cyc(input string tag);
    at_neg(tag);
    at_pos();
  endtask

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [DW-1:0]      data;
    logic [FETCH_W-1:0] exp_lane;
  } lane_vec_t;

  lane_vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{pc: 32'h0001_c004, data: pat(40), exp_lane: 2'b10};
    vecs[1] = '{pc: 32'h0001_c000, data: pat(41), exp_lane: 2'b11};
    vecs[2] = '{pc: 32'h0001_c00c, data: pat(42), exp_lane: 2'b10};
    vecs[3] = '{pc: 32'h0000_0008, data: pat(43), exp_lane: 2'b11};
    vecs[4] = '{pc: 32'hbfc0_0014, data: pat(44), exp_lane: 2'b10};

    drive(0, '0, 0, '0, 0, 0, 0);
    model_reset();
    #1;
    reset_checks("in reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    reset_checks("after release");
    at_pos();
    cyc("first cycle");

    // Four issues, four responses, ID always ready: in-order beats, one cycle after data_ok.
    for (int c = 0; c < 7; c++) begin
      drive(c < 4, PC_W'(32'h1000 + 8 * c), (c >= 1) && (c <= 4), pat(c - 1), 0, 0, 1);
      at_neg("seqA");
      check("seqA valid", 128'(bus.now_to_next_valid_o), 128'((c >= 2) && (c <= 5)));
      if ((c >= 2) && (c <= 5)) begin
        check("seqA pc", 128'(bus.pc_o), 128'(32'h1000 + 8 * (c - 2)));
        check("seqA inst", 128'(bus.inst_o), 128'(pat(c - 2)));
      end
      at_pos();
    end

    // Three issues, one response, flush: two owed beats discarded, the third accepted.
    drive(1, 32'h2000, 0, '0, 0, 0, 0);      cyc("seqB");
    drive(1, 32'h2008, 1, pat(10), 0, 0, 0); cyc("seqB");
    drive(1, 32'h2010, 0, '0, 0, 0, 0);      cyc("seqB");
    drive(0, '0, 0, '0, 1, 0, 0);
    at_neg("seqB flush");
    check("seqB valid forced low on flush", 128'(bus.now_to_next_valid_o), 128'(0));
    at_pos();
    drive(0, '0, 1, pat(20), 0, 0, 0);
    at_neg("seqB");
    check("seqB cancel after flush", 128'(dut.cancel_cnt), 128'(2));
    at_pos();
    drive(0, '0, 1, pat(21), 0, 0, 0);
    at_neg("seqB");
    check("seqB cancel after 1 discard", 128'(dut.cancel_cnt), 128'(1));
    at_pos();
    drive(1, 32'h2004, 0, '0, 0, 0, 0);
    at_neg("seqB");
    check("seqB cancel drained", 128'(dut.cancel_cnt), 128'(0));
    at_pos();
    drive(0, '0, 1, pat(11), 0, 0, 0);       cyc("seqB");
    drive(0, '0, 0, '0, 0, 0, 1);
    at_neg("seqB");
    check("seqB third beat valid", 128'(bus.now_to_next_valid_o), 128'(1));
    check("seqB third beat pc", 128'(bus.pc_o), 128'(32'h2004));
    check("seqB third beat inst", 128'(bus.inst_o), 128'(pat(11)));
    at_pos();

    // Flush together with data_ok and req_issue, two unfilled, both flush sources at once.
    drive(1, 32'h3000, 0, '0, 0, 0, 1);      cyc("seqC");
    drive(1, 32'h3008, 0, '0, 0, 0, 1);      cyc("seqC");
    drive(1, 32'h3010, 1, pat(30), 1, 1, 1); cyc("seqC");
    drive(0, '0, 1, pat(31), 0, 0, 1);
    at_neg("seqC");
    check("seqC cancel after flush", 128'(dut.cancel_cnt), 128'(2));
    at_pos();
    drive(0, '0, 1, pat(32), 0, 0, 1);       cyc("seqC");
    drive(0, '0, 0, '0, 0, 0, 1);
    at_neg("seqC");
    check("seqC cancel drained", 128'(dut.cancel_cnt), 128'(0));
    at_pos();

    // ID stalled, DEPTH issues: allowin drops and stays low until one pop.
    for (int c = 0; c < 8; c++) begin
      drive(c < DEPTH, PC_W'(32'h4000 + 8 * c), (c >= 1) && (c <= DEPTH), pat(50 + c), 0, 0, c == 6);
      at_neg("seqD");
      check("seqD allowin", 128'(bus.now_allowin_o), 128'((c < DEPTH) || (c == 7)));
      at_pos();
    end
    for (int c = 0; c < 4; c++) begin
      drive(0, '0, 0, '0, 0, 0, 1);
      cyc("seqD drain");
    end

    // Lane table: each vector is fetched, filled, then checked at the head.
    foreach (vecs[v]) begin
      drive(1, vecs[v].pc, 0, '0, 0, 0, 1);
      cyc("lane issue");
      drive(0, '0, 1, vecs[v].data, 0, 0, 1);
      cyc("lane fill");
      drive(0, '0, 0, '0, 0, 0, 1);
      at_neg("lane out");
      check("lane valid", 128'(bus.now_to_next_valid_o), 128'(1));
      check("lane pc", 128'(bus.pc_o), 128'(vecs[v].pc));
      check("lane mask", 128'(bus.lane_valid_o), 128'(vecs[v].exp_lane));
      check("lane inst", 128'(bus.inst_o), 128'(vecs[v].data));
      at_pos();
    end

    // Asynchronous reset with three owed responses and one queued request.
    drive(1, 32'h5000, 0, '0, 0, 0, 0);      cyc("seqF");
    drive(1, 32'h5008, 0, '0, 0, 0, 0);      cyc("seqF");
    drive(1, 32'h5010, 0, '0, 0, 0, 0);      cyc("seqF");
    drive(0, '0, 0, '0, 0, 1, 0);            cyc("seqF flush");
    drive(1, 32'h5100, 0, '0, 0, 0, 0);
    at_neg("seqF");
    check("seqF cancel before reset", 128'(dut.cancel_cnt), 128'(3));
    at_pos();
    drive(0, '0, 0, '0, 0, 0, 0);
    at_neg("seqF");
    check("seqF allowin full before reset", 128'(bus.now_allowin_o), 128'(0));
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("async reset");
    check("async reset cancel", 128'(dut.cancel_cnt), 128'(0));
    model_reset();
    @(posedge clk);
    #1;
    reset_checks("reset held");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    reset_checks("reset released");
    at_pos();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit iss, dok, fl, ex, br;
      int which, pending;
      iss     = m_allowin() && ($urandom_range(0, 9) < 6);
      pending = m_cancel + m_unfilled();
      dok     = (pending > 0) && ($urandom_range(0, 1) == 1);
      fl      = ($urandom_range(0, 19) == 0);
      which   = int'($urandom_range(0, 2));
      ex      = fl && (which != 1);
      br      = fl && (which != 0);
      drive(iss, PC_W'({$urandom} & 32'hffff_fffc), dok, DW'({$urandom, $urandom}),
            ex, br, $urandom_range(0, 3) != 0);
      cyc("rand");
    end

`ifdef IF_FETCH_QUEUE_PERF_EN
    drive(0, '0, 0, '0, 0, 0, 1);
    @(negedge clk);
    check("perf discarded beats", 128'(perf_cancel_cnt), 128'(m_discards));
    check("perf stall cycles", 128'(perf_stall_cnt), 128'(m_stalls));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
